// File: rtl/ysyx_22040759_clint_pkg.sv
// Shared constants, access-kind encoding and byte-merge helper for the CLINT.
package ysyx_22040759_clint_pkg;

  localparam logic [31:0] MSIP_OFF     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIME_OFF    = 32'h0000_BFF8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ACC_ERR      = 2'd0,
    ACC_MSIP     = 2'd1,
    ACC_MTIMECMP = 2'd2,
    ACC_MTIME    = 2'd3
  } acc_e;

  // Replace the bytes of old_v selected by strb with the matching bytes of new_v.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22040759_clint_prescaler.sv
// Tick prescaler: one tick every PRESCALE enabled cycles; holds while disabled.
module ysyx_22040759_clint_prescaler #(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_d, pcnt_q;

  // Advance the count while enabled, wrapping to zero on the terminal value.
  always_comb begin
    tick   = tick_en && (pcnt_q == PCNT_LAST);
    pcnt_d = pcnt_q;
    if (tick_en) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/ysyx_22040759_clint_mh.sv
// Multi-hart CLINT: shared mtime, per-hart mtimecmp/msip, registered MMIO response.
module ysyx_22040759_clint_mh
  import ysyx_22040759_clint_pkg::*;
#(
  parameter int          NHART    = 1,
  parameter int          PRESCALE = 100,
  parameter logic [31:0] BASE     = 32'h0200_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              tick_en,
  output logic [NHART-1:0]  mtip,
  output logic [NHART-1:0]  msip
);

  localparam logic [31:0] MSIP_END     = MSIP_OFF + 32'(4 * NHART);
  localparam logic [31:0] MTIMECMP_END = MTIMECMP_OFF + 32'(8 * NHART);

  logic        tick;
  logic [31:0] off;
  acc_e        acc;
  logic [2:0]  hart_sel;
  logic        wr;
  logic        msip_hi;
  logic        msip_wstb;
  logic        msip_wbit;

  logic [63:0] mtime_d, mtime_q;
  logic [63:0] rd_data;

  logic        rsp_valid_d, rsp_valid_q;
  logic [63:0] rsp_rdata_d, rsp_rdata_q;
  logic        rsp_err_d, rsp_err_q;

  logic [63:0]      cmp_all [NHART];
  logic [NHART-1:0] sip_all;
  logic [NHART-1:0] tip_all;

  ysyx_22040759_clint_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_en(tick_en),
    .tick   (tick)
  );

  // Address decode: classify the offset and pick the addressed hart.
  always_comb begin
    off      = req_addr - BASE;
    acc      = ACC_ERR;
    hart_sel = '0;
    if ((off < MSIP_END) && (off[1:0] == 2'b00)) begin
      acc      = ACC_MSIP;
      hart_sel = off[4:2];
    end else if ((off >= MTIMECMP_OFF) && (off < MTIMECMP_END) && (off[2:0] == 3'b000)) begin
      acc      = ACC_MTIMECMP;
      hart_sel = off[5:3];
    end else if (off == MTIME_OFF) begin
      acc      = ACC_MTIME;
    end
    wr        = req_valid && req_wen;
    // Odd-indexed msip words live in the upper half of the 64-bit beat.
    msip_hi   = off[2];
    msip_wstb = msip_hi ? req_wstrb[4] : req_wstrb[0];
    msip_wbit = msip_hi ? req_wdata[32] : req_wdata[0];
  end

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    logic [63:0] cmp_d, cmp_q;
    logic        sip_d, sip_q;
    logic        tip_d, tip_q;

    // Per-hart register updates and registered timer compare.
    always_comb begin
      cmp_d = cmp_q;
      sip_d = sip_q;
      if (wr && (acc == ACC_MTIMECMP) && (hart_sel == 3'(h))) begin
        cmp_d = strb_merge(cmp_q, req_wdata, req_wstrb);
      end
      if (wr && (acc == ACC_MSIP) && (hart_sel == 3'(h)) && msip_wstb) begin
        sip_d = msip_wbit;
      end
      tip_d = (mtime_q >= cmp_q);
    end

    // Per-hart state registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cmp_q <= MTIMECMP_RST;
        sip_q <= 1'b0;
        tip_q <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        sip_q <= sip_d;
        tip_q <= tip_d;
      end
    end

    assign cmp_all[h] = cmp_q;
    assign sip_all[h] = sip_q;
    assign tip_all[h] = tip_q;
  end

  assign msip = sip_all;
  assign mtip = tip_all;

  // mtime advance; a bus write in the same cycle takes priority over the tick.
  always_comb begin
    mtime_d = mtime_q;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr && (acc == ACC_MTIME)) begin
      mtime_d = strb_merge(mtime_q, req_wdata, req_wstrb);
    end
  end

  // mtime register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtime_q <= '0;
    else     mtime_q <= mtime_d;
  end

  // Read mux and response next-state; reads see pre-update register contents.
  always_comb begin
    rd_data = '0;
    unique case (acc)
      ACC_MSIP: begin
        for (int h = 0; h < NHART; h++) begin
          if (hart_sel == 3'(h)) begin
            rd_data = msip_hi ? {31'b0, sip_all[h], 32'b0} : {63'b0, sip_all[h]};
          end
        end
      end
      ACC_MTIMECMP: begin
        for (int h = 0; h < NHART; h++) begin
          if (hart_sel == 3'(h)) rd_data = cmp_all[h];
        end
      end
      ACC_MTIME: rd_data = mtime_q;
      default:   rd_data = '0;
    endcase
    rsp_valid_d = req_valid;
    rsp_err_d   = req_valid && (acc == ACC_ERR);
    rsp_rdata_d = (req_valid && !req_wen && (acc != ACC_ERR)) ? rd_data : 64'd0;
  end

  // Response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
